// File: rtl/ram_fifo_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ram_fifo_ctrl_if
//  Purpose  : Bundles the write stream, read stream and external RAM port of
//             the RAM-backed FIFO controller.
//  Ports    : s_valid/s_ready/s_data   - write-side stream
//             m_valid/m_ready/m_data   - read-side stream
//             ram_w*/ram_r*            - single-cycle-latency RAM port
//  Modports : slave  - the FIFO controller
//             master - the surrounding system (producer, consumer, RAM)
//  Revision : 1.0  initial release
// ============================================================================
interface ram_fifo_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_ren;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  s_valid, s_data, m_ready, ram_rdata,
    output s_ready, m_valid, m_data,
           ram_waddr, ram_wdata, ram_wen, ram_raddr, ram_ren
  );

  modport master (
    output s_valid, s_data, m_ready, ram_rdata,
    input  s_ready, m_valid, m_data,
           ram_waddr, ram_wdata, ram_wen, ram_raddr, ram_ren
  );
endinterface
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ram_fifo_ctrl
//  Purpose  : FIFO controller around an external single-port-pair RAM with
//             one cycle read latency. A two-entry output buffer prefetches
//             from RAM so the read side can sustain one word per cycle.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous active-high reset
//             flush        - synchronous clear of all contents
//             bus          - stream + RAM port bundle (slave modport)
//             count        - words held (RAM + in-flight + output buffer)
//             almost_full  - count >= AF_LEVEL
//             almost_empty - count <= AE_LEVEL
//  Revision : 1.0  initial release
// ============================================================================
module ram_fifo_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 11,
  parameter int AF_LEVEL = (2**ADDR_W) - 4,
  parameter int AE_LEVEL = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          flush,
  ram_fifo_ctrl_if.slave     bus,
  output logic [ADDR_W:0]    count,
  output logic               almost_full,
  output logic               almost_empty
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_V     = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_V     = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   ram_cnt;   // words committed to RAM, not yet read out
  logic              inflight;  // a read issued last edge returns this cycle
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] buf0;      // head of queue
  logic [DATA_W-1:0] buf1;

  logic              push;
  logic              pop;
  logic              rd;
  logic [2:0]        buf_pending;
  logic [1:0]        buf_left;

  // Gating with rst keeps s_ready low while reset is held even though count
  // already reads zero.
  assign bus.s_ready  = ~rst & ~flush & (count < DEPTH_V);
  assign push         = bus.s_valid & bus.s_ready;
  assign bus.m_valid  = (buf_cnt != 2'd0);
  assign pop          = bus.m_valid & bus.m_ready & ~flush;
  assign bus.m_data   = buf0;

  // Buffer slots already claimed after this edge: held words plus the word
  // returning now, minus the one leaving. A read is issued only if its data
  // will have a free slot when it returns.
  assign buf_pending  = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign buf_left     = buf_cnt - {1'b0, pop};
  // ram_cnt only counts words whose write edge has passed, so a word is
  // never read from an address in the cycle it is being written.
  assign rd           = ~flush & (ram_cnt != '0) & (buf_pending < 3'd2);

  assign bus.ram_wen   = push;
  assign bus.ram_waddr = wptr;
  assign bus.ram_wdata = bus.s_data;
  assign bus.ram_ren   = rd;
  assign bus.ram_raddr = rptr;

  assign almost_full  = (count >= AF_V);
  assign almost_empty = (count <= AE_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      count    <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
    end else if (flush) begin
      // Clearing inflight drops whatever the RAM returns next cycle.
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      count    <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      if (rd)   rptr <= rptr + ADDR_W'(1);
      ram_cnt  <= ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(rd);
      count    <= count   + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      inflight <= rd;
      if (pop) buf0 <= buf1;
      // Returning data lands in the first free slot after the pop shift;
      // when that slot is the head it overrides the shift above.
      if (inflight) begin
        if (buf_left == 2'd0) buf0 <= bus.ram_rdata;
        else                  buf1 <= bus.ram_rdata;
      end
      buf_cnt  <= buf_left + {1'b0, inflight};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram_fifo_ctrl
//  Purpose  : Self-checking bench for ram_fifo_ctrl with a behavioural RAM
//             and a queue-based scoreboard checking read-side order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_fifo_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [ADDR_W:0]   count;
  logic              almost_full;
  logic              almost_empty;

  ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read data appears the cycle after the read edge.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
  end

  int checks = 0;
  int passed = 0;
  logic [DATA_W-1:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: samples one time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) chk("pop_unexpected", 64'd1, 64'd0);
        else chk("m_data_order", bus.m_data, sb.pop_front());
      end
      if (bus.s_valid && bus.s_ready) sb.push_back(bus.s_data);
    end
  end

  task automatic wait_empty(input int budget);
    int n = 0;
    while (((count != 0) || bus.m_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {63'd0, (count == 0) && !bus.m_valid}, 64'd1);
  endtask

  task automatic push_n(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = base + DATA_W'(i);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    int gaps;
    int n;

    rst = 1'b1; flush = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    bus.s_valid = 1'b1;
    #1;
    chk("rst_s_ready",  bus.s_ready,  0);
    chk("rst_m_valid",  bus.m_valid,  0);
    chk("rst_ram_wen",  bus.ram_wen,  0);
    chk("rst_ram_ren",  bus.ram_ren,  0);
    chk("rst_m_data",   bus.m_data,   0);
    chk("rst_count",    count,        0);
    chk("rst_ae",       almost_empty, 1);
    chk("rst_af",       almost_full,  0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", bus.s_ready, 1);

    // Single word latency
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 32'hA5A5A5A5;
    @(negedge clk);                                   // edge 1 pushed
    bus.s_valid = 1'b0;
    #1;
    chk("single_ren_e2",   bus.ram_ren, 1);
    chk("single_count1",   count,       1);
    chk("single_mvalid_e1", bus.m_valid, 0);
    @(negedge clk);                                   // after edge 2
    chk("single_mvalid_e2", bus.m_valid, 0);
    @(negedge clk);                                   // after edge 3
    chk("single_mvalid_e3", bus.m_valid, 1);
    chk("single_mdata",     bus.m_data,  32'hA5A5A5A5);
    @(negedge clk);                                   // popped at edge 4
    chk("single_count0",    count,       0);
    chk("single_mvalid_end", bus.m_valid, 0);

    // Fill to DEPTH with the read side stalled
    bus.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h1000_0000 + i;
      @(negedge clk);
      n = i + 1;
      if (n == 1 || n == 4 || n == 5 || n == 2043 || n == 2044 || n == DEPTH) begin
        chk("fill_count", count, n);
        chk("fill_af", almost_full, (n >= 2044) ? 1 : 0);
        chk("fill_ae", almost_empty, (n <= 4) ? 1 : 0);
      end
    end
    bus.s_data = 32'hDEADBEEF;
    #1;
    chk("full_s_ready", bus.s_ready, 0);
    chk("full_ram_wen", bus.ram_wen, 0);
    @(negedge clk);
    chk("full_extra_ignored", count, DEPTH);
    chk("full_hold_mdata", bus.m_data, 32'h1000_0000);
    chk("full_hold_mvalid", bus.m_valid, 1);

    // Pop at full with s_valid high, then push+pop together
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_count", count, DEPTH - 1);
    bus.s_data = 32'hCAFE0001;
    #1;
    chk("after_pop_s_ready", bus.s_ready, 1);
    @(negedge clk);
    chk("push_pop_count", count, DEPTH - 1);
    bus.s_valid = 1'b0;
    wait_empty(5000);

    // Random stream of 5000 incrementing words
    sent = 0; cyc = 0;
    while (sent < 5000 && cyc < 40000) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data  = 32'h2000_0000 + sent;
      bus.m_ready = ($urandom_range(0, 3) != 0);
      #3;
      if (bus.s_valid && bus.s_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    chk("stream_sent", sent, 5000);
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    wait_empty(5000);

    // Both sides always active: no gaps after the initial latency
    gaps = 0;
    for (int k = 0; k < 300; k++) begin
      bus.s_valid = 1'b1; bus.m_ready = 1'b1;
      bus.s_data  = 32'h3000_0000 + k;
      #3;
      if (k == 2) chk("stream_latency_k2", bus.m_valid, 0);
      if (k >= 3 && !bus.m_valid) gaps++;
      @(negedge clk);
    end
    chk("stream_gaps", gaps, 0);
    bus.s_valid = 1'b0;
    wait_empty(100);

    // Flush with a read in flight
    bus.m_ready = 1'b0;
    push_n(11, 32'h4000_0000);
    bus.m_ready = 1'b1;
    #1;
    chk("flush_pre_ren", bus.ram_ren, 1);
    @(negedge clk);
    chk("flush_pre_count", count, 10);
    bus.m_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_ren_suppr", bus.ram_ren, 0);
    chk("flush_s_ready",   bus.s_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_count",  count, 0);
    chk("flush_mvalid", bus.m_valid, 0);
    @(negedge clk);
    chk("flush_stale_dropped", bus.m_valid, 0);
    push_n(1, 32'h1);
    n = 0;
    while (!bus.m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("flush_first_word", bus.m_data, 32'h1);
    bus.m_ready = 1'b1;
    wait_empty(100);

    // Asynchronous reset mid-operation
    bus.m_ready = 1'b0;
    push_n(5, 32'h5000_0000);
    chk("arst_pre_count", count, 5);
    bus.s_valid = 1'b1; bus.s_data = 32'h5555_0000; bus.m_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_s_ready", bus.s_ready, 0);
    chk("arst_m_valid", bus.m_valid, 0);
    chk("arst_ram_wen", bus.ram_wen, 0);
    chk("arst_ram_ren", bus.ram_ren, 0);
    chk("arst_m_data",  bus.m_data,  0);
    chk("arst_count",   count,       0);
    chk("arst_ae",      almost_empty, 1);
    chk("arst_af",      almost_full,  0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_release_s_ready", bus.s_ready, 1);
    push_n(1, 32'h77);
    wait_empty(100);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32, data width; matches RAM WDATA/RDATA.
- ADDR_W, default 11, RAM address width; DEPTH = 2**ADDR_W.
- AF_LEVEL, default DEPTH-4, almost-full threshold.
- AE_LEVEL, default 4, almost-empty threshold.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- s_valid  in  1  write-side data valid.
- s_ready  out  1  write-side can accept.
- s_data  in  DATA_W  write data.
- m_valid  out  1  read-side data valid.
- m_ready  in  1  read-side consumer accepts.
- m_data  out  DATA_W  head-of-queue data.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wen  out  1  RAM write enable.
- ram_raddr  out  ADDR_W  RAM read address.
- ram_ren  out  1  RAM read enable.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the ram_ren edge.
- count  out  ADDR_W+1  entries held: RAM plus in-flight plus output buffer.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.

Function
REQ-003 Push = s_valid & s_ready at a rising edge; pop = m_valid & m_ready at a rising edge.
REQ-004 s_ready SHALL be (count < DEPTH) & ~flush, combinational from registered count.
REQ-005 ram_wen = push; ram_waddr = wptr; ram_wdata = s_data; wptr increments by 1 per push, modulo DEPTH.
REQ-006 A read SHALL be issued (ram_ren=1, ram_raddr=rptr, rptr+1 modulo DEPTH) when RAM occupancy > 0 and (output-buffer occupancy + in-flight reads - pop this cycle) < 2.
REQ-007 RAM occupancy SHALL count only words whose write edge has already occurred, so an address is never read in the same cycle it is written.
REQ-008 The output buffer SHALL be 2 entries, FIFO-ordered; ram_rdata is captured at the edge after the issuing edge; m_data shows the oldest entry; m_valid = buffer non-empty.
REQ-009 Latency: with an empty FIFO, a word pushed at edge E SHALL produce ram_ren sampled at edge E+1 and m_valid=1 after edge E+2.
REQ-010 Throughput: with m_ready held at 1 and continuous pushes, one pop per cycle SHALL be sustained after the initial latency.
REQ-011 count SHALL be count + push - pop; on simultaneous push and pop it is unchanged; it never exceeds DEPTH and never underflows.
REQ-012 Order SHALL be strictly preserved across pointer wrap-around at DEPTH-1 -> 0.
REQ-013 m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-014 flush=1 at an edge SHALL:
- zero wptr, rptr, count and the output buffer;
- discard any in-flight read, so its returning data is not captured;
- suppress push, pop and ram_ren in that cycle.
REQ-015 almost_full and almost_empty SHALL be combinational decodes of count.

Reset
REQ-016 While rst=1, registers SHALL be cleared asynchronously: wptr=0, rptr=0, count=0, buffer empty, in-flight flags 0.
REQ-017 Resulting outputs during reset: s_ready=0, m_valid=0, ram_wen=0, ram_ren=0, m_data=0, almost_empty=1, almost_full=0.
REQ-018 After reset release, s_ready SHALL be 1 from the first clock edge.
REQ-019 A reset asserted mid-operation SHALL abandon all contents; data returned by a read in flight at reset SHALL be ignored.

Verification
REQ-020 Single word: push 0xA5A5A5A5 at edge 1 with m_ready=1 -> ram_ren at edge 2, m_valid=1 with m_data=0xA5A5A5A5 after edge 3, count returns 0 after the pop.
REQ-021 Fill: push 2048 words with m_ready=0 -> s_ready=0 at count=2048, the extra push is ignored, almost_full=1 from count=2044.
REQ-022 Wrap and stream: run 5000 words of incrementing data with random s_valid/m_ready -> output sequence identical, no gaps when both sides are always active.
REQ-023 Simultaneous: at count=2048, pop with s_valid=1 -> count=2047 and no push; next cycle push and pop together -> count stays 2047.
REQ-024 Flush: flush at count=10 with a read in flight -> count=0, m_valid=0 next cycle; a subsequent push of 0x1 is the first word popped.
REQ-025 Async reset: assert rst between edges at count=5 -> all outputs reach their reset values without waiting for a clock edge.
